// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared definitions for the multiply/divide controller.
//            Holds the md_op encodings and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam int MD_OP_W = 3;

    // md_op encodings (110/111 are reserved and ignored)
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'b000;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'b001;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'b010;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'b011;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'b100;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
// Module   : md_if
// Purpose  : E/D-stage handshake bundle of the multiply/divide controller.
//            master : pipeline side (drives start, md_op, src_a, src_b,
//                     d_is_md, and cancel when MD_CANCEL_EN is defined)
//            slave  : controller side (drives busy, stall_md, hi, lo)
// Options  : MD_CANCEL_EN adds the cancel signal.
// Revision : 1.0 - initial release
// ============================================================================
interface md_if;

    logic                        start;
    logic [md_pkg::MD_OP_W-1:0]  md_op;
    logic [31:0]                 src_a;
    logic [31:0]                 src_b;
    logic                        d_is_md;
    logic                        busy;
    logic                        stall_md;
    logic [31:0]                 hi;
    logic [31:0]                 lo;
`ifdef MD_CANCEL_EN
    logic                        cancel;

    modport master (
        output start, md_op, src_a, src_b, d_is_md, cancel,
        input  busy, stall_md, hi, lo
    );
    modport slave (
        input  start, md_op, src_a, src_b, d_is_md, cancel,
        output busy, stall_md, hi, lo
    );
`else
    modport master (
        output start, md_op, src_a, src_b, d_is_md,
        input  busy, stall_md, hi, lo
    );
    modport slave (
        input  start, md_op, src_a, src_b, d_is_md,
        output busy, stall_md, hi, lo
    );
`endif

endinterface
`default_nettype wire

// File: rtl/md_alu.sv
`default_nettype none
// ============================================================================
// Module   : md_alu
// Purpose  : Combinational 32x32 multiply / divide datapath.
// Ports    : md_op    in  3   operation select
//            src_a    in  32  rs operand (multiplicand / dividend)
//            src_b    in  32  rt operand (multiplier / divisor)
//            res_hi   out 32  product[63:32] or remainder
//            res_lo   out 32  product[31:0]  or quotient
//            div_zero out 1   divide operation with a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module md_alu
    import md_pkg::*;
(
    input  wire logic [MD_OP_W-1:0] md_op,
    input  wire logic [31:0]        src_a,
    input  wire logic [31:0]        src_b,
    output logic      [31:0]        res_hi,
    output logic      [31:0]        res_lo,
    output logic                    div_zero
);

    logic        w_sgn_mul;
    logic        w_sgn_div;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_div_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // One multiplier serves both flavours: sign-extending to 64 bits makes
    // the truncated 64-bit product the correct signed result.
    assign w_sgn_mul = (md_op == MD_MULT);
    assign w_mul_a   = {{32{w_sgn_mul & src_a[31]}}, src_a};
    assign w_mul_b   = {{32{w_sgn_mul & src_b[31]}}, src_b};
    assign w_prod    = w_mul_a * w_mul_b;

    // One unsigned divider on magnitudes; signs are restored afterwards so
    // the quotient truncates toward zero and the remainder follows the
    // dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_sgn_div    = (md_op == MD_DIV);
    assign w_a_neg      = w_sgn_div & src_a[31];
    assign w_b_neg      = w_sgn_div & src_b[31];
    assign w_div_a      = w_a_neg ? (~src_a + 32'd1) : src_a;
    assign w_div_b      = w_b_neg ? (~src_b + 32'd1) : src_b;
    // Keep the divider free of X when the divisor is zero; the result is
    // discarded by the controller in that case.
    assign w_div_b_safe = (src_b == 32'd0) ? 32'd1 : w_div_b;
    assign w_q_mag      = w_div_a / w_div_b_safe;
    assign w_r_mag      = w_div_a % w_div_b_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU: begin
                res_hi = w_prod[63:32];
                res_lo = w_prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi   = w_rem;
                res_lo   = w_quot;
                div_zero = (src_b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_ctrl
// Purpose  : Multi-cycle multiply/divide controller with HI/LO registers.
//            One operation per start pulse, busy for a fixed latency, HI/LO
//            committed on completion; stall_md freezes md-class
//            instructions in D while an operation is starting or in flight.
// Ports    : clk      in  1   system clock, rising edge
//            reset_n  in  1   asynchronous active-low reset
//            md       slave md_if: start, md_op, src_a, src_b, d_is_md,
//                     (cancel) in; busy, stall_md, hi, lo out
// Params   : MULT_CYCLES busy cycles for mult/multu (>=1)
//            DIV_CYCLES  busy cycles for div/divu   (>=1)
// Options  : MD_CANCEL_EN enables md.cancel (abort without commit).
// Revision : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  wire logic clk,
    input  wire logic reset_n,
    md_if.slave       md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_div0;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;
    logic             w_cancel;
    logic             w_is_arith;

`ifdef MD_CANCEL_EN
    assign w_cancel = md.cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // mult/multu/div/divu all have md_op[2] clear
    assign w_is_arith = ~md.md_op[2];

    md_alu u_md_alu (
        .md_op    (md.md_op),
        .src_a    (md.src_a),
        .src_b    (md.src_b),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_div0 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (md.start && !w_cancel) begin
                        if (w_is_arith) begin
                            r_pend_hi   <= w_res_hi;
                            r_pend_lo   <= w_res_lo;
                            r_pend_div0 <= w_div_zero;
                            r_cnt       <= md.md_op[1] ? c_div_load : c_mult_load;
                            r_busy      <= 1'b1;
                            r_state     <= ST_RUN;
                        end else if (md.md_op == MD_MTHI) begin
                            r_hi <= md.src_a;
                        end else if (md.md_op == MD_MTLO) begin
                            r_lo <= md.src_a;
                        end
                    end
                end
                ST_RUN: begin
                    // A start arriving here is illegal upstream and is ignored.
                    if (w_cancel) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_cnt_one) begin
                        if (!r_pend_div0) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign md.busy     = r_busy;
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;
    // Includes start so a back-to-back md instruction in D is held.
    assign md.stall_md = md.d_is_md && (r_busy || md.start);

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_ctrl
// Purpose  : Self-checking bench for md_ctrl: directed vector table,
//            hand-written multi-cycle sequences and randomized operations
//            checked against an arithmetic reference model.
// Options  : MD_CANCEL_EN adds the cancel sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    md_if u_if ();

    md_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] h,
                                  inout logic [31:0] l, output int lat);
        longint          sp;
        longint          q;
        longint          r;
        longint unsigned up;
        lat = 0;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32]; l = sp[31:0]; lat = MULT_N;
            end
            3'd1: begin
                up = longint'(a) * longint'(b);
                h = up[63:32]; l = up[31:0]; lat = MULT_N;
            end
            3'd2: begin
                lat = DIV_N;
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    h = r[31:0]; l = q[31:0];
                end
            end
            3'd3: begin
                lat = DIV_N;
                if (b != 0) begin
                    h = a % b; l = a / b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    // Issue one start pulse, then count busy cycles until busy falls.
    // Returns at the first cycle with busy low (results visible).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int nbusy);
        u_if.start = 1'b1;
        u_if.md_op = op;
        u_if.src_a = a;
        u_if.src_b = b;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        nbusy = 0;
        while (u_if.busy === 1'b1 && nbusy < 100) begin
            nbusy++;
            @(posedge clk); #1;
        end
    endtask

    vec_t        tbl [7];
    int          nb;
    logic [31:0] mh;
    logic [31:0] ml;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          mlat;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, MULT_N};
        tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_N};
        tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
        tbl[3] = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_N};
        tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_N};
        tbl[5] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_N};
        tbl[6] = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MULT_N};

        u_if.start   = 1'b0;
        u_if.md_op   = 3'd0;
        u_if.src_a   = 32'd0;
        u_if.src_b   = 32'd0;
        u_if.d_is_md = 1'b0;
`ifdef MD_CANCEL_EN
        u_if.cancel  = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, u_if.busy}, 32'd0);
        chk("reset_hi", u_if.hi, 32'd0);
        chk("reset_lo", u_if.lo, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        u_if.d_is_md = 1'b1;
        #1;
        chk("idle_stall", {31'd0, u_if.stall_md}, 32'd0);
        u_if.d_is_md = 1'b0;

        // ---------------- vector table ----------------
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, nb);
            chk($sformatf("vec%0d_busy_cycles", i), nb, tbl[i].lat);
            chk($sformatf("vec%0d_hi", i), u_if.hi, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), u_if.lo, tbl[i].lo);
        end

        // ---------------- mthi/mtlo back to back ----------------
        do_op(MD_MTHI, 32'h000000A5, 32'h0, nb);
        chk("mthi_busy", nb, 0);
        chk("mthi_hi", u_if.hi, 32'h000000A5);
        do_op(MD_MTLO, 32'h0000005A, 32'h0, nb);
        chk("mtlo_busy", nb, 0);
        chk("mtlo_hi", u_if.hi, 32'h000000A5);
        chk("mtlo_lo", u_if.lo, 32'h0000005A);

        // ---------------- reserved op is ignored ----------------
        do_op(3'd6, 32'hDEADBEEF, 32'h1, nb);
        chk("rsvd_busy", nb, 0);
        chk("rsvd_hi", u_if.hi, 32'h000000A5);
        chk("rsvd_lo", u_if.lo, 32'h0000005A);

        // ---------------- divide by zero keeps hi/lo ----------------
        do_op(MD_MTHI, 32'h00000011, 32'h0, nb);
        do_op(MD_MTLO, 32'h00000022, 32'h0, nb);
        do_op(MD_DIVU, 32'h00000005, 32'h0, nb);
        chk("div0_busy_cycles", nb, DIV_N);
        chk("div0_hi", u_if.hi, 32'h00000011);
        chk("div0_lo", u_if.lo, 32'h00000022);

        // ---------------- stall + ignored start during RUN ----------------
        old_hi = u_if.hi;
        old_lo = u_if.lo;
        u_if.d_is_md = 1'b1;
        u_if.start   = 1'b1;
        u_if.md_op   = MD_MULT;
        u_if.src_a   = 32'd3;
        u_if.src_b   = 32'd4;
        #1;
        chk("stall_start_cycle", {31'd0, u_if.stall_md}, 32'd1);
        @(posedge clk); #1;
        u_if.start = 1'b0;
        nb = 0;
        while (u_if.busy === 1'b1 && nb < 100) begin
            nb++;
            if (nb == 2) begin
                u_if.start = 1'b1;
                u_if.src_a = 32'd2;
                u_if.src_b = 32'd2;
            end else begin
                u_if.start = 1'b0;
            end
            #1;
            chk($sformatf("stall_busy_c%0d", nb), {31'd0, u_if.stall_md}, 32'd1);
            chk($sformatf("hold_hi_c%0d", nb), u_if.hi, old_hi);
            chk($sformatf("hold_lo_c%0d", nb), u_if.lo, old_lo);
            @(posedge clk); #1;
        end
        u_if.start = 1'b0;
        #1;
        chk("stall_busy_cycles", nb, MULT_N);
        chk("stall_released", {31'd0, u_if.stall_md}, 32'd0);
        chk("ignored_start_hi", u_if.hi, 32'd0);
        chk("ignored_start_lo", u_if.lo, 32'd12);
        u_if.d_is_md = 1'b0;

        // ---------------- reset mid-run ----------------
        do_op(MD_MTHI, 32'h00000077, 32'h0, nb);
        u_if.start = 1'b1;
        u_if.md_op = MD_MULT;
        u_if.src_a = 32'd3;
        u_if.src_b = 32'd4;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("midrst_hi", u_if.hi, 32'd0);
        chk("midrst_lo", u_if.lo, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("postrst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("postrst_hi", u_if.hi, 32'd0);
        chk("postrst_lo", u_if.lo, 32'd0);

`ifdef MD_CANCEL_EN
        // ---------------- cancel ----------------
        do_op(MD_MTHI, 32'h00000033, 32'h0, nb);
        do_op(MD_MTLO, 32'h00000044, 32'h0, nb);
        u_if.start = 1'b1;
        u_if.md_op = MD_DIV;
        u_if.src_a = 32'd100;
        u_if.src_b = 32'd7;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        @(posedge clk); #1;
        u_if.cancel = 1'b1;
        @(posedge clk); #1;
        u_if.cancel = 1'b0;
        chk("cancel_busy", {31'd0, u_if.busy}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("cancel_hi", u_if.hi, 32'h00000033);
        chk("cancel_lo", u_if.lo, 32'h00000044);
        u_if.cancel = 1'b1;
        do_op(MD_MTHI, 32'h00000099, 32'h0, nb);
        u_if.cancel = 1'b0;
        chk("cancel_mthi_hi", u_if.hi, 32'h00000033);
`endif

        // ---------------- randomized against model ----------------
        do_op(MD_MTHI, 32'h12345678, 32'h0, nb);
        do_op(MD_MTLO, 32'h9ABCDEF0, 32'h0, nb);
        mh = 32'h12345678;
        ml = 32'h9ABCDEF0;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'h80000000;
                default: ;
            endcase
            model(op, a, b, mh, ml, mlat);
            do_op(op, a, b, nb);
            chk($sformatf("rnd%0d_op%0d_cycles", i, op), nb, mlat);
            chk($sformatf("rnd%0d_op%0d_hi", i, op), u_if.hi, mh);
            chk($sformatf("rnd%0d_op%0d_lo", i, op), u_if.lo, ml);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller with HI/LO registers for the 5-stage MIPS pipeline; sits beside the E-stage ALU.
- Accepts one operation per start pulse and holds busy for a fixed latency.
- Commits HI/LO on completion.
- Raises stall_md so the D-stage stall logic freezes any mult/div/mfhi/mflo/mthi/mtlo instruction that arrives while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  E-stage pulse requesting an md operation.
- md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
- src_a  in  32  E-stage forwarded rs value.
- src_b  in  32  E-stage forwarded rt value.
- d_is_md  in  1  D-stage instruction is an md-class instruction.
- busy  out  1  operation in flight.
- stall_md  out  1  combinational: d_is_md && (busy || start).
- hi  out  32  HI register.
- lo  out  32  LO register.
- cancel  in  1  present only with MD_CANCEL_EN.

Behaviour:
- Reset: async, while reset_n=0. Forces state=IDLE, cnt=0, busy=0, hi=0, lo=0, and pending result=0.
- States are IDLE and RUN.
- IDLE with start=1, md_op mult/multu/div/divu:
  - Compute the 64-bit result combinationally from src_a/src_b and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, then go to RUN.
- IDLE with start=1, md_op mthi/mtlo:
  - hi or lo takes src_a at that edge. No busy. Next cycle the new value is visible.
- Reserved md_op with start: ignored.
- RUN:
  - busy=1 and cnt decrements each edge.
  - At the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, state<=IDLE.
- Latency: start sampled at edge k gives busy=1 for cycles k+1..k+N. New hi/lo are visible from cycle k+N+1, with busy=0.
- start while in RUN: ignored; the pending operation is unaffected. Upstream stall guarantees this never happens legally.
- hi/lo hold their old values for the whole of RUN, so an mfhi issued before start reads the old value.
- Arithmetic:
  - mult is signed 32x32->64; multu is unsigned. HI = bits 63:32, LO = bits 31:0.
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: the operation still runs DIV_CYCLES, and hi/lo remain unchanged at commit.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- stall_md is high in the start cycle itself, so a back-to-back md instruction in D is held.
- Reset asserted mid-RUN: the operation is lost and outputs return to their reset values immediately.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - cancel port exists.
  - cancel=1 in RUN sends state to IDLE at the next edge, with no hi/lo commit.
  - cancel=1 together with start in IDLE suppresses the start, including mthi/mtlo.
  - cancel has priority over commit when cnt==1.
- Undefined: port absent, and every started operation always commits.

Decomposition:
- Shared package md_pkg holds:
  - the md_op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - the state encoding ST_IDLE, ST_RUN.
- Sub-module md_alu: purely combinational; md_op, src_a, src_b -> res_hi, res_lo, div_zero.
- md_ctrl holds the FSM, the counter and the HI/LO registers.

Test Plan:
- mult, src_a=0xFFFFFFFD (-3), src_b=5 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. divu 7/2 -> lo=3, hi=1.
- divu 5/0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Stall and ignored start:
  - d_is_md=1 during the start cycle and the busy cycles -> stall_md=1 throughout.
  - stall_md=0 once busy falls.
  - A second start with mult 2*2 during RUN -> ignored, and the first result is committed.
- Reset and back-to-back moves:
  - reset_n low in cycle 3 of a mult -> busy=0, hi=lo=0 immediately, and no commit after release.
  - mthi 0xA5 then mtlo 0x5A on consecutive cycles -> busy stays 0, and hi=0xA5, lo=0x5A.
- (MD_CANCEL_EN) cancel at cycle 2 of div 100/7 -> busy drops the next cycle, and hi/lo keep their prior values.
